// File: rtl/life_seed_loader.sv
// Seed loader for the Game-of-Life grid: buffers a frame of row words, commits it
// to the per-cell init vector, runs the grid reset/seed sequence and counts generations.
module life_seed_loader #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   row_valid,
  output logic                   row_ready,
  input  logic                   row_sof,
  input  logic [COLS-1:0]        row_data,
  output logic                   grid_rst,
  output logic [ROWS*COLS-1:0]   grid_init,
  output logic                   running,
  output logic [GEN_W-1:0]       gen_count,
  output logic                   frame_err
);

  localparam int                IDX_W    = (ROWS > 2) ? $clog2(ROWS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(ROWS - 1);
  localparam logic [GEN_W-1:0]  GEN_MAX  = {GEN_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_GRST = 3'd2,
    S_SEED = 3'd3,
    S_RUN  = 3'd4
  } state_t;

  state_t                 r_state;
  logic [IDX_W-1:0]       r_idx;
  logic [ROWS*COLS-1:0]   r_buf;
  logic                   r_run_loading;
  logic [ROWS*COLS-1:0]   r_grid_init;
  logic                   r_running;
  logic [GEN_W-1:0]       r_gen;
  logic                   r_frame_err;

  logic                   w_accepting;
  logic                   w_loading;
  logic                   w_row_ready;
  logic                   w_xfer;
  logic [ROWS*COLS-1:0]   w_final_buf;

  // Decode which states accept rows and whether a frame is partially loaded.
  always_comb begin
    w_accepting = 1'b0;
    w_loading   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_accepting = 1'b1;
        w_loading   = 1'b0;
      end
      S_LOAD: begin
        w_accepting = 1'b1;
        w_loading   = 1'b1;
      end
      S_RUN: begin
        w_accepting = 1'b1;
        w_loading   = r_run_loading;
      end
      default: begin
        w_accepting = 1'b0;
        w_loading   = 1'b0;
      end
    endcase
  end

  // The committed frame includes the final row arriving on the commit edge.
  always_comb begin
    w_final_buf = r_buf;
    w_final_buf[(ROWS-1)*COLS +: COLS] = row_data;
  end

  assign w_row_ready = ~rst & w_accepting;
  assign w_xfer      = row_valid & w_row_ready;

  assign row_ready = w_row_ready;
  assign grid_rst  = rst | (r_state == S_GRST);
  assign grid_init = r_grid_init;
  assign running   = r_running;
  assign gen_count = r_gen;
  assign frame_err = r_frame_err;

  // Frame loading, commit and grid sequencing state machine.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_buf         <= '0;
      r_run_loading <= 1'b0;
      r_grid_init   <= '0;
      r_running     <= 1'b0;
      r_gen         <= '0;
      r_frame_err   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE, S_LOAD, S_RUN: begin
          if (r_state == S_RUN) begin
            r_gen <= (r_gen == GEN_MAX) ? r_gen : r_gen + GEN_W'(1);
          end
          if (w_xfer) begin
            if (row_sof) begin
              // A start-of-frame always restarts, even on what would be the final row.
              r_buf[COLS-1:0] <= row_data;
              r_idx           <= IDX_W'(1);
              r_frame_err     <= w_loading;
              if (r_state == S_IDLE) begin
                r_state <= S_LOAD;
              end
              if (r_state == S_RUN) begin
                r_run_loading <= 1'b1;
              end
            end else if (w_loading) begin
              r_buf[r_idx*COLS +: COLS] <= row_data;
              if (r_idx == LAST_IDX) begin
                r_grid_init   <= w_final_buf;
                r_state       <= S_GRST;
                r_running     <= 1'b0;
                r_gen         <= '0;
                r_run_loading <= 1'b0;
                r_idx         <= '0;
              end else begin
                r_idx <= r_idx + IDX_W'(1);
              end
            end
          end
        end
        S_GRST: begin
          r_state   <= S_SEED;
          r_running <= 1'b0;
        end
        S_SEED: begin
          r_state   <= S_RUN;
          r_gen     <= '0;
          r_running <= 1'b1;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_life_seed_loader.sv
// Directed table-driven bench for life_seed_loader on a 4x4 grid; a second
// instance with a 4-bit generation counter shares the stimulus to check saturation.
module tb_life_seed_loader;

  logic        clk;
  logic        rst;
  logic        row_valid;
  logic        row_sof;
  logic [3:0]  row_data;

  logic        row_ready;
  logic        grid_rst;
  logic [15:0] grid_init;
  logic        running;
  logic [15:0] gen_count;
  logic        frame_err;

  logic        row_ready_s;
  logic        grid_rst_s;
  logic [15:0] grid_init_s;
  logic        running_s;
  logic [3:0]  gen_count_s;
  logic        frame_err_s;

  int checks;
  int errors;

  typedef struct {
    logic        rst;
    logic        valid;
    logic        sof;
    logic [3:0]  data;
    logic        ready;
    logic        grst;
    logic        run;
    logic [15:0] gen;
    logic [15:0] init;
    logic        ferr;
  } vec_t;

  vec_t tv1[$];
  vec_t tv2[$];

  life_seed_loader #(.ROWS(4), .COLS(4), .GEN_W(16)) dut (
    .clk(clk), .rst(rst), .row_valid(row_valid), .row_ready(row_ready),
    .row_sof(row_sof), .row_data(row_data), .grid_rst(grid_rst),
    .grid_init(grid_init), .running(running), .gen_count(gen_count),
    .frame_err(frame_err)
  );

  life_seed_loader #(.ROWS(4), .COLS(4), .GEN_W(4)) dut_s (
    .clk(clk), .rst(rst), .row_valid(row_valid), .row_ready(row_ready_s),
    .row_sof(row_sof), .row_data(row_data), .grid_rst(grid_rst_s),
    .grid_init(grid_init_s), .running(running_s), .gen_count(gen_count_s),
    .frame_err(frame_err_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic vec_t mk(input int r, input int v, input int s, input int d,
                              input int rdy, input int gr, input int rn, input int g,
                              input int ini, input int fe);
    vec_t x;
    x.rst   = r[0];
    x.valid = v[0];
    x.sof   = s[0];
    x.data  = d[3:0];
    x.ready = rdy[0];
    x.grst  = gr[0];
    x.run   = rn[0];
    x.gen   = g[15:0];
    x.init  = ini[15:0];
    x.ferr  = fe[0];
    return x;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic apply_vec(input string tag, input int idx, input vec_t v);
    logic [15:0] sat;
    rst       = v.rst;
    row_valid = v.valid;
    row_sof   = v.sof;
    row_data  = v.data;
    #1;
    sat = (v.gen > 16'd15) ? 16'd15 : v.gen;
    chk({tag, ".row_ready"}, idx, 32'(row_ready), 32'(v.ready));
    chk({tag, ".grid_rst"},  idx, 32'(grid_rst),  32'(v.grst));
    chk({tag, ".running"},   idx, 32'(running),   32'(v.run));
    chk({tag, ".gen_count"}, idx, 32'(gen_count), 32'(v.gen));
    chk({tag, ".grid_init"}, idx, 32'(grid_init), 32'(v.init));
    chk({tag, ".frame_err"}, idx, 32'(frame_err), 32'(v.ferr));
    chk({tag, ".gen_sat"},   idx, 32'(gen_count_s), 32'(sat));
    chk({tag, ".init_sat"},  idx, 32'(grid_init_s), 32'(v.init));
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // frame 1: diagonal, then latency of grid_rst / running / gen_count
    tv1.push_back(mk(0,1,1,'h1, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h2, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h4, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h8, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,0,0,'h0, 0,1,0,0,'h8421,0));
    tv1.push_back(mk(0,0,0,'h0, 0,0,0,0,'h8421,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,0,'h8421,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,1,'h8421,0));
    tv1.push_back(mk(1,0,0,'h0, 0,1,1,2,'h8421,0));
    // IDLE discards non-sof rows
    tv1.push_back(mk(0,1,0,'h5, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h6, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h7, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,1,'hF, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h0, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h0, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'hF, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,0,0,'h0, 0,1,0,0,'hF00F,0));
    tv1.push_back(mk(0,0,0,'h0, 0,0,0,0,'hF00F,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,0,'hF00F,0));
    tv1.push_back(mk(1,0,0,'h0, 0,1,1,1,'hF00F,0));
    // restart mid-load
    tv1.push_back(mk(0,1,1,'h9, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h9, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,1,'h3, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h3, 1,0,0,0,'h0000,1));
    tv1.push_back(mk(0,1,0,'h0, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,1,0,'h0, 1,0,0,0,'h0000,0));
    tv1.push_back(mk(0,0,0,'h0, 0,1,0,0,'h0033,0));
    tv1.push_back(mk(0,0,0,'h0, 0,0,0,0,'h0033,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,0,'h0033,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,1,'h0033,0));
    // reload while running, with valid gaps; valid ignored while not ready
    tv1.push_back(mk(0,1,1,'h6, 1,0,1,2,'h0033,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,3,'h0033,0));
    tv1.push_back(mk(0,1,0,'h6, 1,0,1,4,'h0033,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,5,'h0033,0));
    tv1.push_back(mk(0,1,0,'h0, 1,0,1,6,'h0033,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,7,'h0033,0));
    tv1.push_back(mk(0,1,0,'h0, 1,0,1,8,'h0033,0));
    tv1.push_back(mk(0,1,1,'hF, 0,1,0,0,'h0066,0));
    tv1.push_back(mk(0,1,0,'hF, 0,0,0,0,'h0066,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,0,'h0066,0));
    tv1.push_back(mk(0,0,0,'h0, 1,0,1,1,'h0066,0));

    // rst mid-load in RUN, stale rows discarded, then rst during SEED
    tv2.push_back(mk(0,1,1,'hA, 1,0,1,22,'h0066,0));
    tv2.push_back(mk(0,1,0,'hB, 1,0,1,23,'h0066,0));
    tv2.push_back(mk(1,1,0,'hC, 0,1,1,24,'h0066,0));
    tv2.push_back(mk(0,1,0,'hD, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,1,0,'hE, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,1,1,'h1, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,1,0,'h1, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,1,0,'h1, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,1,0,'h1, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,0,0,'h0, 0,1,0,0,'h1111,0));
    tv2.push_back(mk(1,0,0,'h0, 0,1,0,0,'h1111,0));
    tv2.push_back(mk(0,1,1,'h2, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,1,0,'h2, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,1,0,'h2, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,1,0,'h2, 1,0,0,0,'h0000,0));
    tv2.push_back(mk(0,0,0,'h0, 0,1,0,0,'h2222,0));
    tv2.push_back(mk(0,0,0,'h0, 0,0,0,0,'h2222,0));
    tv2.push_back(mk(0,0,0,'h0, 1,0,1,0,'h2222,0));
    tv2.push_back(mk(0,0,0,'h0, 1,0,1,1,'h2222,0));

    // initial reset
    rst       = 1'b1;
    row_valid = 1'b0;
    row_sof   = 1'b0;
    row_data  = 4'h0;
    #1;
    chk("rst.grid_rst_comb", 0, 32'(grid_rst), 32'd1);
    chk("rst.row_ready_comb", 0, 32'(row_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("rst.grid_init", 0, 32'(grid_init), 32'd0);
    chk("rst.running",   0, 32'(running),   32'd0);
    chk("rst.gen_count", 0, 32'(gen_count), 32'd0);
    chk("rst.frame_err", 0, 32'(frame_err), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < tv1.size(); i++) begin
      apply_vec("t1", i, tv1[i]);
    end

    // long run: narrow counter saturates at 15, wide one keeps counting
    rst       = 1'b0;
    row_valid = 1'b0;
    row_sof   = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      chk("sat.gen_wide", k, 32'(gen_count), 32'(2 + k));
      chk("sat.gen_narrow", k, 32'(gen_count_s), ((2 + k) > 15) ? 32'd15 : 32'(2 + k));
      chk("sat.running_narrow", k, 32'(running_s), 32'd1);
      @(posedge clk);
      #1;
    end

    for (int i = 0; i < tv2.size(); i++) begin
      apply_vec("t2", i, tv2[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
